// File: rtl/rv32i_halt_monitor.sv
// rv32i_halt_monitor: end-of-program detector and watchdog fed from instruction-memory read data
// Ports: clk_i/reset_i (sync, active-high); enable_i gates all activity; inst_valid_i/inst_i fetch stream;
//        halt_o/timeout_o/done_o sticky flags; pair_cnt_o halt/fill pairs; cycle_cnt_o enabled cycles;
//        inst_cnt_o accepted fetches
module rv32i_halt_monitor #(
   parameter logic [31:0] HALT_INST      = 32'h0000006F,
   parameter logic [31:0] FILL_INST      = 32'h00000013,
   parameter int          REPEAT_N       = 5,
   parameter int          CONSECUTIVE    = 0,
   parameter int          TIMEOUT_CYCLES = 1500,
   parameter int          CNT_W          = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             inst_valid_i,
   input  logic [31:0]      inst_i,
   output logic             halt_o,
   output logic             timeout_o,
   output logic             done_o,
   output logic [7:0]       pair_cnt_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] inst_cnt_o
);
   localparam logic [2:0] S_IDLE = 3'd0, S_GOT = 3'd1, S_SKIP = 3'd2, S_HALTED = 3'd3, S_TMO = 3'd4;
   logic [2:0]       r_state, w_state_nxt;
   logic [7:0]       r_pair, w_pair_nxt, w_pair_inc;
   logic [CNT_W-1:0] r_cycle, r_inst, w_cyc_inc;
   logic             r_halt, r_tmo, r_done;
   logic             w_live, w_acc, w_is_halt, w_is_fill, w_halt_hit, w_wd_hit, w_cyc_sat, w_inst_sat;
   assign w_live     = enable_i && r_state != S_HALTED && r_state != S_TMO;
   assign w_acc      = w_live && inst_valid_i;
   assign w_is_halt  = inst_i == HALT_INST;
   assign w_is_fill  = inst_i == FILL_INST;
   assign w_pair_inc = r_pair + 8'd1;
   assign w_cyc_inc  = r_cycle + 1'b1;
   assign w_cyc_sat  = &r_cycle;
   assign w_inst_sat = &r_inst;
   assign w_halt_hit = w_acc && r_state == S_GOT && w_is_fill && w_pair_inc == 8'(REPEAT_N);
   assign w_wd_hit   = TIMEOUT_CYCLES != 0 && w_live && !w_cyc_sat && w_cyc_inc == CNT_W'(TIMEOUT_CYCLES);
   always_comb begin
      w_state_nxt = r_state;
      w_pair_nxt  = r_pair;
      if (w_acc) begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = w_is_halt ? S_GOT : S_IDLE;
               w_pair_nxt  = (!w_is_halt && CONSECUTIVE != 0) ? 8'd0 : r_pair;
            end
            S_GOT: begin
               w_state_nxt = w_is_fill ? S_IDLE : S_SKIP;
               w_pair_nxt  = w_is_fill ? w_pair_inc : 8'd0;
            end
            S_SKIP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = r_state;
         endcase
      end
      // halt completion takes priority over a coincident watchdog expiry
      if (w_wd_hit) w_state_nxt = S_TMO;
      if (w_halt_hit) w_state_nxt = S_HALTED;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_pair  <= '0;
         r_cycle <= '0;
         r_inst  <= '0;
         r_halt  <= 1'b0;
         r_tmo   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pair  <= w_pair_nxt;
         if (w_live && !w_cyc_sat) r_cycle <= w_cyc_inc;
         if (w_acc && !w_inst_sat) r_inst <= r_inst + 1'b1;
         r_halt  <= r_halt | w_halt_hit;
         r_tmo   <= r_tmo | (w_wd_hit & ~w_halt_hit);
         r_done  <= r_done | w_halt_hit | w_wd_hit;
      end
   end
   assign halt_o      = r_halt;
   assign timeout_o   = r_tmo;
   assign done_o      = r_done;
   assign pair_cnt_o  = r_pair;
   assign cycle_cnt_o = r_cycle;
   assign inst_cnt_o  = r_inst;
endmodule

// File: tb/tb_rv32i_halt_monitor.sv
// tb_rv32i_halt_monitor: scoreboard bench driving four parameter variants with a shared directed stream
module tb_rv32i_halt_monitor;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, en, vld;
   logic [31:0] inst;
   logic        halt [4];
   logic        tmo  [4];
   logic        done [4];
   logic [7:0]  pair [4];
   logic [31:0] cyc  [4];
   logic [31:0] icnt [4];
   // d0 default, d1 CONSECUTIVE=1, d2 TIMEOUT_CYCLES=20, d3 TIMEOUT_CYCLES=10
   for (genvar g = 0; g < 4; g++) begin : g_dut
      rv32i_halt_monitor #(
         .CONSECUTIVE   (g == 1 ? 1 : 0),
         .TIMEOUT_CYCLES(g == 2 ? 20 : (g == 3 ? 10 : 1500))
      ) u_dut (
         .clk_i       (clk),
         .reset_i     (rst),
         .enable_i    (en),
         .inst_valid_i(vld),
         .inst_i      (inst),
         .halt_o      (halt[g]),
         .timeout_o   (tmo[g]),
         .done_o      (done[g]),
         .pair_cnt_o  (pair[g]),
         .cycle_cnt_o (cyc[g]),
         .inst_cnt_o  (icnt[g])
      );
   end
   typedef struct {
      int          tgt;
      int          d;
      string       nm;
      logic        h;
      logic        t;
      logic [7:0]  p;
      logic [31:0] c;
      logic [31:0] i;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int n_chk = 0, n_pass = 0, cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].tgt <= cyc_n) begin
         e = q.pop_front();
         n_chk++;
         if (e.tgt == cyc_n && halt[e.d] == e.h && tmo[e.d] == e.t && done[e.d] == (e.h | e.t) &&
             pair[e.d] == e.p && cyc[e.d] == e.c && icnt[e.d] == e.i)
            n_pass++;
         else
            $display("FAIL %s: dut%0d got halt=%b tmo=%b done=%b pair=%0d cyc=%0d inst=%0d want halt=%b tmo=%b done=%b pair=%0d cyc=%0d inst=%0d",
                     e.nm, e.d, halt[e.d], tmo[e.d], done[e.d], pair[e.d], cyc[e.d], icnt[e.d],
                     e.h, e.t, e.h | e.t, e.p, e.c, e.i);
      end
   end
   task automatic ex(string nm, int d, logic h, logic t, int p, int c, int i);
      exp_t x;
      x.tgt = cyc_n; x.d = d; x.nm = nm; x.h = h; x.t = t;
      x.p = 8'(p); x.c = 32'(c); x.i = 32'(i);
      q.push_back(x);
   endtask
   task automatic st(logic [31:0] v, logic e_in = 1'b1, logic r = 1'b0);
      inst = v; vld = 1'b1; en = e_in; rst = r;
      @(posedge clk);
      #1;
   endtask
   task automatic rs();
      st(32'h0, 1'b0, 1'b1);
   endtask
   task automatic pr();
      st(32'h6F);
      st(32'h13);
   endtask
   initial begin
      rst = 1'b1; en = 1'b0; vld = 1'b0; inst = '0;
      rs();
      for (int d = 0; d < 4; d++) ex("reset", d, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         pr();
         ex("pairs", 0, k == 5, 0, k, 2 * k, 2 * k);
      end
      st(32'h13);
      ex("halt_hold", 0, 1, 0, 5, 10, 10);
      rs();
      pr();
      ex("pre_clear", 0, 0, 0, 1, 2, 2);
      st(32'h6F);
      st(32'h33);
      ex("nonfill_clear", 0, 0, 0, 0, 4, 4);
      st(32'h6F);
      st(32'h13);
      ex("skip", 0, 0, 0, 0, 6, 6);
      for (int k = 1; k <= 5; k++) begin
         pr();
         ex("after_skip", 0, k == 5, 0, k, 6 + 2 * k, 6 + 2 * k);
      end
      rs();
      for (int k = 0; k < 3; k++) pr();
      ex("consec_3", 1, 0, 0, 3, 6, 6);
      st(32'h00A00093);
      ex("consec_clear", 1, 0, 0, 0, 7, 7);
      ex("nonconsec_keep", 0, 0, 0, 3, 7, 7);
      for (int k = 1; k <= 5; k++) begin
         pr();
         ex("consec_pairs", 1, k == 5, 0, k, 7 + 2 * k, 7 + 2 * k);
      end
      ex("nonconsec_halt", 0, 1, 0, 5, 11, 11);
      rs();
      for (int k = 0; k < 19; k++) st(32'h33);
      ex("wd_19", 2, 0, 0, 0, 19, 19);
      ex("wd10_expired", 3, 0, 1, 0, 10, 10);
      st(32'h33);
      ex("wd_20", 2, 0, 1, 0, 20, 20);
      st(32'h33);
      ex("wd_hold", 2, 0, 1, 0, 20, 20);
      rs();
      for (int k = 0; k < 10; k++) st(32'h33);
      for (int k = 0; k < 3; k++) st(32'h33, 1'b0);
      ex("freeze", 2, 0, 0, 0, 10, 10);
      for (int k = 0; k < 9; k++) st(32'h33);
      ex("freeze_19", 2, 0, 0, 0, 19, 19);
      st(32'h33);
      ex("freeze_20", 2, 0, 1, 0, 20, 20);
      rs();
      for (int k = 0; k < 4; k++) pr();
      st(32'h6F);
      ex("race_9", 3, 0, 0, 4, 9, 9);
      st(32'h13);
      ex("race_halt_wins", 3, 1, 0, 5, 10, 10);
      rs();
      for (int k = 0; k < 3; k++) pr();
      ex("pre_reset", 0, 0, 0, 3, 6, 6);
      rs();
      ex("mid_reset", 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         pr();
         ex("fresh", 0, k == 5, 0, k, 2 * k, 2 * k);
      end
      for (int k = 0; k < 3; k++) st(32'h0, 1'b0);
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
